// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl_pkg
// Purpose : Shared state encodings, register-index constants and the
//           load-use compare used by the hazard/stall sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    // Sequencer state, explicit 2-bit encoding
    typedef logic [1:0] state_t;

    localparam state_t     c_ST_RUN     = 2'd0;
    localparam state_t     c_ST_LDSTALL = 2'd1;
    localparam state_t     c_ST_MEMWAIT = 2'd2;

    // X31 as a destination is XZR: writes are discarded, so it never hazards
    localparam logic [4:0] c_XZR_IDX    = 5'd31;

    // Remaining load-stall cycles never exceed 2 (LOAD_STALL_CYCLES <= 3)
    localparam int         c_LDCNT_W    = 2;

    // True when the ID instruction reads the register a load in EX will write
    function automatic logic isLoadUse(
        input logic       memRead,
        input logic [4:0] exRd,
        input logic [4:0] idRn,
        input logic [4:0] idRm,
        input logic       usesRm
    );
        return memRead && (exRd != c_XZR_IDX) &&
               ((exRd == idRn) || (usesRm && (exRd == idRm)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones, with enable and an
//           asynchronous active-low clear.
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clrN,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clk or negedge i_clrN) begin
        if (!i_clrN) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl
// Purpose : Hazard and stall sequencer beside the ID stage. Injects load-use
//           bubbles, holds the whole pipe during data-memory waits and
//           flushes the younger stages when a branch resolves taken in MEM.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rd,
    input  logic [4:0]       IFID_Rn,
    input  logic [4:0]       IFID_Rm,
    input  logic             IFID_UsesRm,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    output logic             Stall,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             PipeHold,
    output logic             FlushIFID,
    output logic             FlushIDEX,
    output logic             FlushEXMEM,
    output logic [CNT_W-1:0] StallCount,
    output logic             MemTimeout
);

    localparam int                    c_BUSY_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_BUSY_W-1:0]   c_BUSY_MAX = c_BUSY_W'(MEM_TIMEOUT);
    localparam logic [c_LDCNT_W-1:0]  c_LD_INIT  = c_LDCNT_W'(LOAD_STALL_CYCLES - 1);

    state_t                r_state;
    state_t                w_nextState;
    state_t                w_evalState;
    logic [c_LDCNT_W-1:0]  r_ldCnt;
    logic [c_LDCNT_W-1:0]  w_ldCntNext;
    logic [c_BUSY_W-1:0]   r_busyCnt;
    logic                  r_memTimeout;
    logic                  w_luh;
    logic                  w_cntEn;

    assign w_luh = isLoadUse(IDEX_MemRead, IDEX_Rd, IFID_Rn, IFID_Rm, IFID_UsesRm);

    // Leaving MEMWAIT, the same cycle behaves as the state being resumed
    assign w_evalState = (r_state == c_ST_MEMWAIT)
                       ? ((r_ldCnt != '0) ? c_ST_LDSTALL : c_ST_RUN)
                       : r_state;

    // State and remaining-bubble registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
            r_ldCnt <= '0;
        end else begin
            r_state <= w_nextState;
            r_ldCnt <= w_ldCntNext;
        end
    end

    // Next state and output decode; priority MemBusy > BranchTaken > load-use
    always_comb begin
        Stall       = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        PipeHold    = 1'b0;
        FlushIFID   = 1'b0;
        FlushIDEX   = 1'b0;
        FlushEXMEM  = 1'b0;
        w_nextState = c_ST_RUN;
        w_ldCntNext = r_ldCnt;

        if (!rst_n) begin
            // Keep the front end frozen and bubbles flowing while in reset
            Stall     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (MemBusy) begin
            // Freeze everything; a pending load stall resumes afterwards
            PipeHold    = 1'b1;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            w_nextState = c_ST_MEMWAIT;
        end else if (BranchTaken) begin
            // Younger instructions are wrong-path, so any load stall is moot
            FlushIFID   = 1'b1;
            FlushIDEX   = 1'b1;
            FlushEXMEM  = 1'b1;
            w_ldCntNext = '0;
        end else if (w_evalState == c_ST_LDSTALL) begin
            Stall     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            if (r_ldCnt <= c_LDCNT_W'(1)) begin
                w_ldCntNext = '0;
            end else begin
                w_ldCntNext = r_ldCnt - 1'b1;
                w_nextState = c_ST_LDSTALL;
            end
        end else if (w_luh) begin
            Stall     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            if (LOAD_STALL_CYCLES > 1) begin
                w_ldCntNext = c_LD_INIT;
                w_nextState = c_ST_LDSTALL;
            end
        end
    end

    // Consecutive busy-cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busyCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else if (MemBusy) begin
            if (r_busyCnt != c_BUSY_MAX) begin
                r_busyCnt <= r_busyCnt + 1'b1;
            end
            if (r_busyCnt == (c_BUSY_MAX - 1'b1)) begin
                r_memTimeout <= 1'b1;
            end
        end else begin
            r_busyCnt <= '0;
        end
    end

    assign MemTimeout = r_memTimeout;
    assign w_cntEn    = Stall | PipeHold;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stallCnt (
        .clk     (clk),
        .i_clrN  (rst_n),
        .i_en    (w_cntEn),
        .o_count (StallCount)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Purpose : Directed self-checking bench for hazard_stall_ctrl. Instance A
//           uses one load bubble, instance B uses three; both share inputs.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IDEX_MemRead, IFID_UsesRm, BranchTaken, MemBusy;
    logic [4:0]  IDEX_Rd, IFID_Rn, IFID_Rm;

    logic        aStall, aPCWrite, aIFIDWrite, aPipeHold, aFlushIFID, aFlushIDEX, aFlushEXMEM, aMemTimeout;
    logic [15:0] aStallCount;
    logic        bStall, bPCWrite, bIFIDWrite, bPipeHold, bFlushIFID, bFlushIDEX, bFlushEXMEM, bMemTimeout;
    logic [15:0] bStallCount;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(64), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
        .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .IFID_UsesRm(IFID_UsesRm),
        .BranchTaken(BranchTaken), .MemBusy(MemBusy), .Stall(aStall), .PCWrite(aPCWrite),
        .IFIDWrite(aIFIDWrite), .PipeHold(aPipeHold), .FlushIFID(aFlushIFID),
        .FlushIDEX(aFlushIDEX), .FlushEXMEM(aFlushEXMEM), .StallCount(aStallCount),
        .MemTimeout(aMemTimeout)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
        .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .IFID_UsesRm(IFID_UsesRm),
        .BranchTaken(BranchTaken), .MemBusy(MemBusy), .Stall(bStall), .PCWrite(bPCWrite),
        .IFIDWrite(bIFIDWrite), .PipeHold(bPipeHold), .FlushIFID(bFlushIFID),
        .FlushIDEX(bFlushIDEX), .FlushEXMEM(bFlushEXMEM), .StallCount(bStallCount),
        .MemTimeout(bMemTimeout)
    );

    task automatic clearIns();
        IDEX_MemRead = 1'b0; IDEX_Rd = 5'd0; IFID_Rn = 5'd1; IFID_Rm = 5'd2;
        IFID_UsesRm = 1'b0; BranchTaken = 1'b0; MemBusy = 1'b0;
    endtask

    task automatic setHazard5();
        IDEX_MemRead = 1'b1; IDEX_Rd = 5'd5; IFID_Rn = 5'd5;
    endtask

    // Short reset pulse inside the low clock phase, no edge in between
    task automatic doReset();
        @(negedge clk);
        clearIns();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clearIns();
        @(negedge clk);
        #1;
        nCompared++;
        if ({aStall, aPCWrite, aIFIDWrite, aPipeHold} !== 4'b1000) begin
            nMismatched++; $display("FAIL reset_ctrl got %b want 1000", {aStall, aPCWrite, aIFIDWrite, aPipeHold});
        end
        nCompared++;
        if ({aFlushIFID, aFlushIDEX, aFlushEXMEM} !== 3'b000) begin
            nMismatched++; $display("FAIL reset_flush got %b want 000", {aFlushIFID, aFlushIDEX, aFlushEXMEM});
        end
        nCompared++;
        if (aStallCount !== 16'd0 || aMemTimeout !== 1'b0) begin
            nMismatched++; $display("FAIL reset_regs got cnt=%0d to=%b want cnt=0 to=0", aStallCount, aMemTimeout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        doReset();
        @(negedge clk); setHazard5(); #1;
        nCompared++;
        if ({aStall, aPCWrite, aIFIDWrite} !== 3'b100) begin
            nMismatched++; $display("FAIL lu_stall got %b want 100", {aStall, aPCWrite, aIFIDWrite});
        end
        @(negedge clk); clearIns(); #1;
        nCompared++;
        if ({aStall, aPCWrite, aIFIDWrite} !== 3'b011) begin
            nMismatched++; $display("FAIL lu_release got %b want 011", {aStall, aPCWrite, aIFIDWrite});
        end
        nCompared++;
        if (aStallCount !== 16'd1) begin
            nMismatched++; $display("FAIL lu_count got %0d want 1", aStallCount);
        end
    endtask

    task automatic test_xzr_rm();
        doReset();
        @(negedge clk);
        IDEX_MemRead = 1'b1; IDEX_Rd = 5'd31; IFID_Rn = 5'd31; IFID_Rm = 5'd31; IFID_UsesRm = 1'b1;
        #1;
        nCompared++;
        if (aStall !== 1'b0) begin nMismatched++; $display("FAIL xzr_stall got %b want 0", aStall); end
        @(negedge clk);
        IDEX_Rd = 5'd7; IFID_Rn = 5'd3; IFID_Rm = 5'd7; IFID_UsesRm = 1'b0;
        #1;
        nCompared++;
        if (aStall !== 1'b0) begin nMismatched++; $display("FAIL rm_unused got %b want 0", aStall); end
        @(negedge clk); IFID_UsesRm = 1'b1; #1;
        nCompared++;
        if (aStall !== 1'b1) begin nMismatched++; $display("FAIL rm_used got %b want 1", aStall); end
        @(negedge clk); IDEX_MemRead = 1'b0; #1;
        nCompared++;
        if (aStall !== 1'b0) begin nMismatched++; $display("FAIL rm_noload got %b want 0", aStall); end
        clearIns();
    endtask

    task automatic test_multi_stall();
        doReset();
        @(negedge clk); setHazard5(); #1;
        nCompared++;
        if (bStall !== 1'b1) begin nMismatched++; $display("FAIL ms_c0 got %b want 1", bStall); end
        @(negedge clk); clearIns(); #1;
        nCompared++;
        if (bStall !== 1'b1) begin nMismatched++; $display("FAIL ms_c1 got %b want 1", bStall); end
        @(negedge clk); #1;
        nCompared++;
        if (bStall !== 1'b1) begin nMismatched++; $display("FAIL ms_c2 got %b want 1", bStall); end
        @(negedge clk); #1;
        nCompared++;
        if ({bStall, bPCWrite} !== 2'b01) begin nMismatched++; $display("FAIL ms_c3 got %b want 01", {bStall, bPCWrite}); end
        nCompared++;
        if (bStallCount !== 16'd3) begin nMismatched++; $display("FAIL ms_count got %0d want 3", bStallCount); end
    endtask

    task automatic test_branch_cancel();
        doReset();
        @(negedge clk); setHazard5(); #1;
        @(negedge clk); clearIns(); BranchTaken = 1'b1; #1;
        nCompared++;
        if ({bFlushIFID, bFlushIDEX, bFlushEXMEM, bStall, bPCWrite} !== 5'b11101) begin
            nMismatched++; $display("FAIL bc_flush got %b want 11101", {bFlushIFID, bFlushIDEX, bFlushEXMEM, bStall, bPCWrite});
        end
        @(negedge clk); clearIns(); #1;
        nCompared++;
        if ({bFlushIFID, bFlushIDEX, bFlushEXMEM, bStall} !== 4'b0000) begin
            nMismatched++; $display("FAIL bc_after got %b want 0000", {bFlushIFID, bFlushIDEX, bFlushEXMEM, bStall});
        end
        nCompared++;
        if (bStallCount !== 16'd1) begin nMismatched++; $display("FAIL bc_count got %0d want 1", bStallCount); end
    endtask

    task automatic test_memwait();
        doReset();
        @(negedge clk); setHazard5(); #1;
        @(negedge clk); clearIns();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); MemBusy = 1'b1; #1;
            nCompared++;
            if ({bPipeHold, bStall, bPCWrite, bIFIDWrite} !== 4'b1000) begin
                nMismatched++; $display("FAIL mw_hold%0d got %b want 1000", i, {bPipeHold, bStall, bPCWrite, bIFIDWrite});
            end
        end
        @(negedge clk); MemBusy = 1'b0; #1;
        nCompared++;
        if ({bPipeHold, bStall, bPCWrite} !== 3'b010) begin
            nMismatched++; $display("FAIL mw_resume got %b want 010", {bPipeHold, bStall, bPCWrite});
        end
        @(negedge clk); #1;
        nCompared++;
        if ({bStall, bPCWrite} !== 2'b01) begin nMismatched++; $display("FAIL mw_run got %b want 01", {bStall, bPCWrite}); end
        nCompared++;
        if (bStallCount !== 16'd8) begin nMismatched++; $display("FAIL mw_count got %0d want 8", bStallCount); end
    endtask

    task automatic test_priority();
        doReset();
        @(negedge clk); setHazard5(); BranchTaken = 1'b1; MemBusy = 1'b1; #1;
        nCompared++;
        if ({aPipeHold, aStall, aPCWrite, aFlushIFID, aFlushIDEX, aFlushEXMEM} !== 6'b100000) begin
            nMismatched++; $display("FAIL pr_busy got %b want 100000", {aPipeHold, aStall, aPCWrite, aFlushIFID, aFlushIDEX, aFlushEXMEM});
        end
        @(negedge clk); MemBusy = 1'b0; #1;
        nCompared++;
        if ({aPipeHold, aStall, aPCWrite, aFlushIFID, aFlushIDEX, aFlushEXMEM} !== 6'b001111) begin
            nMismatched++; $display("FAIL pr_branch got %b want 001111", {aPipeHold, aStall, aPCWrite, aFlushIFID, aFlushIDEX, aFlushEXMEM});
        end
        @(negedge clk); clearIns(); #1;
        nCompared++;
        if ({aStall, aFlushIFID} !== 2'b00) begin nMismatched++; $display("FAIL pr_idle got %b want 00", {aStall, aFlushIFID}); end
    endtask

    task automatic test_timeout();
        doReset();
        for (int i = 0; i < 63; i++) begin
            @(negedge clk); MemBusy = 1'b1;
        end
        @(negedge clk); MemBusy = 1'b0; #1;
        nCompared++;
        if (aMemTimeout !== 1'b0) begin nMismatched++; $display("FAIL to_63 got %b want 0", aMemTimeout); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); MemBusy = 1'b1; #1;
            if (i == 63) begin
                nCompared++;
                if (aMemTimeout !== 1'b0) begin nMismatched++; $display("FAIL to_early got %b want 0", aMemTimeout); end
            end
        end
        @(negedge clk); MemBusy = 1'b0; #1;
        nCompared++;
        if (aMemTimeout !== 1'b1 || bMemTimeout !== 1'b1) begin
            nMismatched++; $display("FAIL to_set got a=%b b=%b want 1 1", aMemTimeout, bMemTimeout);
        end
        nCompared++;
        if (aStallCount !== 16'd127) begin nMismatched++; $display("FAIL to_count got %0d want 127", aStallCount); end
        repeat (3) @(negedge clk);
        #1;
        nCompared++;
        if (aMemTimeout !== 1'b1) begin nMismatched++; $display("FAIL to_sticky got %b want 1", aMemTimeout); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); setHazard5();
        @(negedge clk); clearIns(); #1;
        nCompared++;
        if (bStall !== 1'b1) begin nMismatched++; $display("FAIL ar_ldstall got %b want 1", bStall); end
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({bStall, bPCWrite, bIFIDWrite, bPipeHold} !== 4'b1000) begin
            nMismatched++; $display("FAIL ar_ctrl got %b want 1000", {bStall, bPCWrite, bIFIDWrite, bPipeHold});
        end
        nCompared++;
        if (bStallCount !== 16'd0 || bMemTimeout !== 1'b0) begin
            nMismatched++; $display("FAIL ar_regs got cnt=%0d to=%b want cnt=0 to=0", bStallCount, bMemTimeout);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        nCompared++;
        if ({bStall, bPCWrite, bIFIDWrite} !== 3'b011) begin
            nMismatched++; $display("FAIL ar_run got %b want 011", {bStall, bPCWrite, bIFIDWrite});
        end
    endtask

    initial begin
        clearIns();
        test_reset();
        test_load_use();
        test_xzr_rm();
        test_multi_stall();
        test_branch_cancel();
        test_memwait();
        test_priority();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
